in_line_burst_reader: RTL and testbench
=======================================

Name: in_line_burst_reader

Overview:
Consumer end of the in-line offset/burst descriptor stream produced by the DMA line offset former. Each accepted descriptor {offset, burst_len, last} becomes one AXI4 read-address request at base_addr_i + offset. The block tracks outstanding bursts, counts returning R beats, and forwards read data downstream, marking the final beat of each line. It sits between the offset former and the AXI read master port of the DMA read channel.

Parameters:
ADDR_W, 32, address and offset width
DATA_W, 64, AXI data width in bits; power of 2, at least 8
MAX_OUTSTANDING, 4, max bursts issued but not fully returned; power of 2, at least 2

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
base_addr_i  in  ADDR_W  line base byte address; sampled at descriptor accept
desc_offset_i  in  ADDR_W  byte offset of burst within line
desc_burst_len_i  in  8  AXI-style length (beats-1)
desc_last_i  in  1  final burst of line
desc_valid_i  in  1  descriptor valid
desc_ready_o  out  1  descriptor accepted when valid&ready
m_araddr_o  out  ADDR_W  read address
m_arlen_o  out  8  burst length
m_arsize_o  out  3  log2(DATA_W/8), constant
m_arburst_o  out  2  INCR (2'b01), constant
m_arvalid_o  out  1  AR valid
m_arready_i  in  1  AR ready
m_rdata_i  in  DATA_W  read data
m_rresp_i  in  2  read response
m_rlast_i  in  1  AXI last beat of burst
m_rvalid_i  in  1  R valid
m_rready_o  out  1  R ready
data_o  out  DATA_W  forwarded data
data_last_o  out  1  final beat of line
data_valid_o  out  1  data valid
data_ready_i  in  1  downstream ready
line_done_o  out  1  one-cycle pulse after final beat of line transfers
err_o  out  1  sticky error flag

Behaviour:
- Reset values: m_arvalid_o=0, m_araddr_o=0, m_arlen_o=0, data_valid_o=0, data_last_o=0, m_rready_o=0, line_done_o=0, err_o=0, tracking FIFO empty, beat counter 0.
- AR stage: single output register. desc_ready_o = (!m_arvalid_o | m_arready_i) & !fifo_full. A descriptor is accepted on desc_valid_i & desc_ready_o. On accept, next cycle: m_arvalid_o=1, m_araddr_o=base_addr_i+desc_offset_i (modulo 2^ADDR_W, no carry out), m_arlen_o=desc_burst_len_i. Latency from descriptor to AR is one cycle. AR outputs hold stable while m_arvalid_o & !m_arready_i.
- Tracking FIFO: depth MAX_OUTSTANDING, entries {len[7:0], last}. Push on descriptor accept, pop on the final beat of the head burst. Push and pop may occur in the same cycle; occupancy is unchanged. fifo_full blocks accept, so a full FIFO blocks further bursts until one burst completes.
- R path is combinational pass-through, gated by the tracking FIFO. When the FIFO is empty: m_rready_o=0 and data_valid_o=0. Otherwise m_rready_o=data_ready_i, data_valid_o=m_rvalid_i, and data_o=m_rdata_i.
- Beat counter: increments on each R handshake. When the counter equals head.len on a handshake, the counter clears and the FIFO pops. On that beat, data_last_o=head.last; on every other beat data_last_o=0.
- line_done_o: registered; pulses 1 cycle after a handshake with data_last_o=1.
- Errors (err_o set, sticky until reset; data still forwarded):
  - m_rlast_i != (counter==head.len) on a handshake;
  - m_rresp_i != 0 on a handshake.
- Reset mid-operation: all state is cleared asynchronously. Outstanding AXI beats are the system's responsibility.

Decomposition:
- dma_pkg holds: AXI_BURST_INCR constant; axsize function computing $clog2(DATA_W/8); burst_track_t struct {len, last}.
- One sub-module, burst_track_fifo: synchronous FIFO with full/empty flags and same-cycle push/pop.

Test Plan:
- Base 0x1000_0000, DATA_W=64, descriptors (0,15,0),(128,15,0),(256,15,0),(384,11,1), all ready high. Required: araddr 0x1000_0000/0x1000_0080/0x1000_0100/0x1000_0180, arlen 15/15/15/11; 60 beats forwarded; data_last_o on beat 60 only; line_done_o pulses 1 cycle later.
- m_arready_i low for 5 cycles with a pending AR. Required: AR outputs stable; desc_ready_o=0; accept resumes the cycle arready rises.
- MAX_OUTSTANDING=4, 5 descriptors, no R returns. Required: 4 accepted, desc_ready_o=0; 5th accepted the cycle after burst 1's final beat.
- data_ready_i toggled every cycle during a 16-beat burst. Required: m_rready_o mirrors it; exactly 16 transfers; no beats lost or duplicated.
- m_rlast_i asserted on beat 8 of a len-15 burst. Required: err_o=1 and stays 1; data forwarding continues.
- rst_ni dropped mid-burst (beat 5 of 16). Required: all outputs at reset values immediately; after release, a new line runs cleanly.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared DMA read-channel definitions: AXI burst constants, size helper and
// the per-burst tracking record used by the in-line burst reader.
package dma_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    function automatic logic [2:0] axsize(input int unsigned data_w);
        return 3'($clog2(data_w / 8));
    endfunction

    typedef struct packed {
        logic [7:0] len;
        logic       last;
    } burst_track_t;

endpackage

// File: rtl/burst_track_fifo.sv
// Synchronous FIFO of outstanding burst records; push and pop may coincide.
module burst_track_fifo
    import dma_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  burst_track_t push_data_i,
    input  logic         pop_i,
    output burst_track_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    burst_track_t     mem_q [DEPTH];
    burst_track_t     mem_d [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & !full_o;
    assign do_pop  = pop_i & !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/in_line_burst_reader.sv
// Turns {offset, burst_len, last} descriptors into AXI4 AR requests and
// forwards the returning R beats downstream, flagging the last beat of a line.
module in_line_burst_reader
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] desc_offset_i,
    input  logic [7:0]        desc_burst_len_i,
    input  logic              desc_last_i,
    input  logic              desc_valid_i,
    output logic              desc_ready_o,
    output logic [ADDR_W-1:0] m_araddr_o,
    output logic [7:0]        m_arlen_o,
    output logic [2:0]        m_arsize_o,
    output logic [1:0]        m_arburst_o,
    output logic              m_arvalid_o,
    input  logic              m_arready_i,
    input  logic [DATA_W-1:0] m_rdata_i,
    input  logic [1:0]        m_rresp_i,
    input  logic              m_rlast_i,
    input  logic              m_rvalid_i,
    output logic              m_rready_o,
    output logic [DATA_W-1:0] data_o,
    output logic              data_last_o,
    output logic              data_valid_o,
    input  logic              data_ready_i,
    output logic              line_done_o,
    output logic              err_o
);

    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [7:0]        beat_q, beat_d;
    logic              line_done_q, line_done_d;
    logic              err_q, err_d;

    logic              desc_accept;
    logic              fifo_full, fifo_empty;
    logic              r_hs, final_beat, head_pop;
    burst_track_t      head, push_entry;

    assign desc_ready_o = (!arvalid_q | m_arready_i) & !fifo_full;
    assign desc_accept  = desc_valid_i & desc_ready_o;
    assign push_entry   = '{len: desc_burst_len_i, last: desc_last_i};

    burst_track_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_track (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (desc_accept),
        .push_data_i (push_entry),
        .pop_i       (head_pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // R channel is only opened while a burst is being tracked.
    assign m_rready_o   = !fifo_empty & data_ready_i;
    assign data_valid_o = !fifo_empty & m_rvalid_i;
    assign data_o       = m_rdata_i;
    assign r_hs         = m_rvalid_i & m_rready_o;
    assign final_beat   = (beat_q == head.len);
    assign head_pop     = r_hs & final_beat;
    assign data_last_o  = data_valid_o & final_beat & head.last;

    assign m_arvalid_o  = arvalid_q;
    assign m_araddr_o   = araddr_q;
    assign m_arlen_o    = arlen_q;
    assign m_arsize_o   = axsize(DATA_W);
    assign m_arburst_o  = AXI_BURST_INCR;
    assign line_done_o  = line_done_q;
    assign err_o        = err_q;

    always_comb begin
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        beat_d      = beat_q;
        line_done_d = r_hs & final_beat & head.last;
        err_d       = err_q;
        if (arvalid_q & m_arready_i) begin
            arvalid_d = 1'b0;
        end
        if (desc_accept) begin
            arvalid_d = 1'b1;
            araddr_d  = base_addr_i + desc_offset_i;
            arlen_d   = desc_burst_len_i;
        end
        if (r_hs) begin
            beat_d = final_beat ? '0 : beat_q + 8'd1;
            if ((m_rlast_i != final_beat) || (m_rresp_i != 2'b00)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            beat_q      <= '0;
            line_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            beat_q      <= beat_d;
            line_done_q <= line_done_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_in_line_burst_reader.sv
// Directed self-checking bench for in_line_burst_reader (default parameters).
module tb_in_line_burst_reader;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] base_addr_i;
    logic [31:0] desc_offset_i;
    logic [7:0]  desc_burst_len_i;
    logic        desc_last_i;
    logic        desc_valid_i;
    logic        desc_ready_o;
    logic [31:0] m_araddr_o;
    logic [7:0]  m_arlen_o;
    logic [2:0]  m_arsize_o;
    logic [1:0]  m_arburst_o;
    logic        m_arvalid_o;
    logic        m_arready_i;
    logic [63:0] m_rdata_i;
    logic [1:0]  m_rresp_i;
    logic        m_rlast_i;
    logic        m_rvalid_i;
    logic        m_rready_o;
    logic [63:0] data_o;
    logic        data_last_o;
    logic        data_valid_o;
    logic        data_ready_i;
    logic        line_done_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    in_line_burst_reader #(
        .ADDR_W          (32),
        .DATA_W          (64),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .base_addr_i      (base_addr_i),
        .desc_offset_i    (desc_offset_i),
        .desc_burst_len_i (desc_burst_len_i),
        .desc_last_i      (desc_last_i),
        .desc_valid_i     (desc_valid_i),
        .desc_ready_o     (desc_ready_o),
        .m_araddr_o       (m_araddr_o),
        .m_arlen_o        (m_arlen_o),
        .m_arsize_o       (m_arsize_o),
        .m_arburst_o      (m_arburst_o),
        .m_arvalid_o      (m_arvalid_o),
        .m_arready_i      (m_arready_i),
        .m_rdata_i        (m_rdata_i),
        .m_rresp_i        (m_rresp_i),
        .m_rlast_i        (m_rlast_i),
        .m_rvalid_i       (m_rvalid_i),
        .m_rready_o       (m_rready_o),
        .data_o           (data_o),
        .data_last_o      (data_last_o),
        .data_valid_o     (data_valid_o),
        .data_ready_i     (data_ready_i),
        .line_done_o      (line_done_o),
        .err_o            (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_desc(input logic [31:0] off, input logic [7:0] len,
                             input logic last, input logic [31:0] exp_addr);
        desc_valid_i     = 1'b1;
        desc_offset_i    = off;
        desc_burst_len_i = len;
        desc_last_i      = last;
        #1;
        chk("desc_ready", desc_ready_o, 1'b1);
        tick();
        desc_valid_i = 1'b0;
        chk("arvalid", m_arvalid_o, 1'b1);
        chk("araddr", m_araddr_o, exp_addr);
        chk("arlen", m_arlen_o, len);
    endtask

    task automatic do_beat(input logic [63:0] d, input logic rlast, input logic exp_last);
        m_rvalid_i = 1'b1;
        m_rdata_i  = d;
        m_rlast_i  = rlast;
        #1;
        chk("data_valid", data_valid_o, 1'b1);
        chk("rready", m_rready_o, 1'b1);
        chk("data", data_o, d);
        chk("data_last", data_last_o, exp_last);
        tick();
        m_rvalid_i = 1'b0;
        m_rlast_i  = 1'b0;
    endtask

    initial begin
        int lens [4];
        int xfers;
        int cyc;
        logic hs;
        logic saw_last;

        rst_ni           = 1'b0;
        base_addr_i      = 32'h1000_0000;
        desc_offset_i    = '0;
        desc_burst_len_i = '0;
        desc_last_i      = 1'b0;
        desc_valid_i     = 1'b0;
        m_arready_i      = 1'b1;
        m_rdata_i        = '0;
        m_rresp_i        = 2'b00;
        m_rlast_i        = 1'b0;
        m_rvalid_i       = 1'b0;
        data_ready_i     = 1'b1;
        #2;
        chk("rst_arvalid", m_arvalid_o, 1'b0);
        chk("rst_araddr", m_araddr_o, 32'h0);
        chk("rst_arlen", m_arlen_o, 8'h0);
        chk("rst_rready", m_rready_o, 1'b0);
        chk("rst_data_valid", data_valid_o, 1'b0);
        chk("rst_line_done", line_done_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("arsize", m_arsize_o, 3'd3);
        chk("arburst", m_arburst_o, 2'b01);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // Full line: four bursts, 60 beats, last flagged on beat 60 only.
        send_desc(32'd0,   8'd15, 1'b0, 32'h1000_0000);
        send_desc(32'd128, 8'd15, 1'b0, 32'h1000_0080);
        send_desc(32'd256, 8'd15, 1'b0, 32'h1000_0100);
        send_desc(32'd384, 8'd11, 1'b1, 32'h1000_0180);
        tick();
        chk("ar_consumed", m_arvalid_o, 1'b0);
        chk("full_blocks", desc_ready_o, 1'b0);
        lens = '{16, 16, 16, 12};
        xfers = 0;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < lens[b]; k++) begin
                xfers++;
                do_beat(64'(b * 256 + k), k == lens[b] - 1, xfers == 60);
                if (xfers == 59) chk("no_early_line_done", line_done_o, 1'b0);
            end
        end
        chk("line_beats", xfers, 60);
        chk("line_done_pulse", line_done_o, 1'b1);
        tick();
        chk("line_done_clear", line_done_o, 1'b0);
        chk("line_err", err_o, 1'b0);

        // AR stall: outputs hold, no accept until arready rises; address wraps.
        m_arready_i = 1'b0;
        send_desc(32'h40, 8'd2, 1'b0, 32'h1000_0040);
        desc_valid_i     = 1'b1;
        base_addr_i      = 32'hFFFF_FFF0;
        desc_offset_i    = 32'h20;
        desc_burst_len_i = 8'd0;
        desc_last_i      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_desc_ready", desc_ready_o, 1'b0);
            tick();
            chk("stall_arvalid", m_arvalid_o, 1'b1);
            chk("stall_araddr", m_araddr_o, 32'h1000_0040);
            chk("stall_arlen", m_arlen_o, 8'd2);
        end
        m_arready_i = 1'b1;
        #1;
        chk("resume_desc_ready", desc_ready_o, 1'b1);
        tick();
        desc_valid_i = 1'b0;
        chk("wrap_arvalid", m_arvalid_o, 1'b1);
        chk("wrap_araddr", m_araddr_o, 32'h0000_0010);
        chk("wrap_arlen", m_arlen_o, 8'd0);
        tick();
        chk("wrap_ar_consumed", m_arvalid_o, 1'b0);
        do_beat(64'hA0, 1'b0, 1'b0);
        do_beat(64'hA1, 1'b0, 1'b0);
        do_beat(64'hA2, 1'b1, 1'b0);
        do_beat(64'hB0, 1'b1, 1'b1);
        chk("stall_line_done", line_done_o, 1'b1);

        // Outstanding limit: the 5th descriptor waits for burst 1 to finish.
        base_addr_i = 32'h2000_0000;
        send_desc(32'h000, 8'd1, 1'b0, 32'h2000_0000);
        send_desc(32'h100, 8'd1, 1'b0, 32'h2000_0100);
        send_desc(32'h200, 8'd1, 1'b0, 32'h2000_0200);
        send_desc(32'h300, 8'd1, 1'b1, 32'h2000_0300);
        desc_valid_i     = 1'b1;
        desc_offset_i    = 32'h400;
        desc_burst_len_i = 8'd1;
        desc_last_i      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("limit_desc_ready", desc_ready_o, 1'b0);
            tick();
        end
        m_rvalid_i = 1'b1;
        m_rdata_i  = 64'hC0;
        #1;
        chk("limit_beat0_ready", desc_ready_o, 1'b0);
        tick();
        m_rdata_i  = 64'hC1;
        m_rlast_i  = 1'b1;
        #1;
        chk("limit_final_ready", desc_ready_o, 1'b0);
        tick();
        m_rvalid_i = 1'b0;
        m_rlast_i  = 1'b0;
        chk("limit_after_pop_ready", desc_ready_o, 1'b1);
        tick();
        desc_valid_i = 1'b0;
        chk("limit5_arvalid", m_arvalid_o, 1'b1);
        chk("limit5_araddr", m_araddr_o, 32'h2000_0400);
        for (int b = 1; b < 5; b++) begin
            do_beat(64'(16 * b), 1'b0, 1'b0);
            do_beat(64'(16 * b + 1), 1'b1, b >= 3);
        end
        chk("limit_line_done", line_done_o, 1'b1);

        // Downstream backpressure toggling every cycle during a 16-beat burst.
        send_desc(32'h800, 8'd15, 1'b1, 32'h2000_0800);
        xfers        = 0;
        cyc          = 0;
        saw_last     = 1'b0;
        data_ready_i = 1'b1;
        m_rvalid_i   = 1'b1;
        while (xfers < 16 && cyc < 64) begin
            data_ready_i = ~data_ready_i;
            m_rdata_i    = 64'(xfers);
            m_rlast_i    = (xfers == 15);
            #1;
            chk("bp_rready", m_rready_o, data_ready_i);
            hs = data_ready_i;
            if (hs) begin
                chk("bp_data", data_o, 64'(xfers));
                chk("bp_last", data_last_o, xfers == 15);
                if (data_last_o) saw_last = 1'b1;
            end
            tick();
            if (hs) xfers++;
            cyc++;
        end
        chk("bp_transfers", xfers, 16);
        chk("bp_saw_last", saw_last, 1'b1);
        chk("bp_line_done", line_done_o, 1'b1);
        data_ready_i = 1'b1;
        m_rlast_i    = 1'b0;
        #1;
        chk("empty_gates_valid", data_valid_o, 1'b0);
        chk("empty_gates_rready", m_rready_o, 1'b0);
        m_rvalid_i = 1'b0;
        tick();
        chk("bp_err", err_o, 1'b0);

        // Early rlast on beat 8 of a len-15 burst: sticky error, data keeps flowing.
        send_desc(32'h0, 8'd15, 1'b1, 32'h2000_0000);
        for (int k = 0; k < 16; k++) begin
            do_beat(64'(32'h5000 + k), (k == 7) || (k == 15), k == 15);
            if (k == 6) chk("err_before", err_o, 1'b0);
            if (k >= 7) chk("err_sticky", err_o, 1'b1);
        end
        chk("err_line_done", line_done_o, 1'b1);
        tick();
        chk("err_held", err_o, 1'b1);

        // Asynchronous reset in the middle of a burst (during beat 5 of 16).
        send_desc(32'h40, 8'd15, 1'b1, 32'h2000_0040);
        for (int k = 0; k < 4; k++) begin
            do_beat(64'(k), 1'b0, 1'b0);
        end
        m_rvalid_i = 1'b1;
        m_rdata_i  = 64'd4;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_arvalid", m_arvalid_o, 1'b0);
        chk("mid_rst_araddr", m_araddr_o, 32'h0);
        chk("mid_rst_arlen", m_arlen_o, 8'h0);
        chk("mid_rst_data_valid", data_valid_o, 1'b0);
        chk("mid_rst_data_last", data_last_o, 1'b0);
        chk("mid_rst_rready", m_rready_o, 1'b0);
        chk("mid_rst_line_done", line_done_o, 1'b0);
        chk("mid_rst_err", err_o, 1'b0);
        m_rvalid_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        chk("post_rst_desc_ready", desc_ready_o, 1'b1);
        base_addr_i = 32'h3000_0000;
        send_desc(32'h100, 8'd3, 1'b1, 32'h3000_0100);
        for (int k = 0; k < 4; k++) begin
            do_beat(64'(32'h7000 + k), k == 3, k == 3);
        end
        chk("post_rst_line_done", line_done_o, 1'b1);
        chk("post_rst_err", err_o, 1'b0);
        tick();
        chk("post_rst_line_done_clear", line_done_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
